// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the writeback-select stage.
//   - LD_* : load-type encodings carried on ld_type.
//   - WB_* : writeback-source indices into src_flat.
//   - wb_state_e : occupancy of the WB stage register.
package cpu_pkg;

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b100;
   localparam logic [2:0] LD_LHU = 3'b101;

   localparam int WB_PC4  = 0;
   localparam int WB_ALU  = 1;
   localparam int WB_MEM  = 2;
   localparam int WB_ZERO = 3;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_sel_pipe_load_ext.sv
// load_ext: combinational load-data extraction and extension.
//   word       in  32  raw memory read word
//   ld_type    in  3   LB/LH/LW/LBU/LHU
//   ld_addr_lo in  2   byte offset of the load address
//   data       out 32  extracted, sign/zero-extended data
// Misaligned halfwords are not trapped; the halfword picked by
// ld_addr_lo[1] is returned. Unknown ld_type passes the word through.
module load_ext
   import cpu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [2:0]  ld_type,
   input  logic [1:0]  ld_addr_lo,
   output logic [31:0] data
);

   logic [31:0] shifted;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      shifted = word >> {ld_addr_lo, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = ld_addr_lo[1] ? word[31:16] : word[15:0];
      case (ld_type)
         LD_LB:   data = {{24{byte_v[7]}}, byte_v};
         LD_LBU:  data = {24'h0, byte_v};
         LD_LH:   data = {{16{half_v[15]}}, half_v};
         LD_LHU:  data = {16'h0, half_v};
         LD_LW:   data = word;
         default: data = word;
      endcase
   end

endmodule

// File: rtl/wb_sel_pipe.sv
// wb_sel_pipe: writeback-source select, load extension and WB register.
//   clk, rst      rising-edge clock, async active-high reset
//   stall, flush  hold / bubble the WB register (flush wins)
//   in_valid      incoming instruction valid
//   src_flat      NUM_SRC sources, source k at [k*WIDTH +: WIDTH]
//   sel           source index; sel >= NUM_SRC writes zero
//   ld_type, ld_addr_lo  load extension controls (MEM_SRC only)
//   rd_in, we_in  destination register and write request
//   wb_valid, wb_we, wb_rd, wb_data  registered WB outputs
//   wb_data_nxt   combinational selected data, for forwarding
module wb_sel_pipe
   import cpu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int NUM_SRC   = 4,
   parameter int SEL_W     = 2,
   parameter int MEM_SRC   = WB_MEM,
   parameter int RF_ADDR_W = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [NUM_SRC*WIDTH-1:0] src_flat,
   input  logic [SEL_W-1:0]         sel,
   input  logic [2:0]               ld_type,
   input  logic [1:0]               ld_addr_lo,
   input  logic [RF_ADDR_W-1:0]     rd_in,
   input  logic                     we_in,
   output logic                     wb_valid,
   output logic                     wb_we,
   output logic [RF_ADDR_W-1:0]     wb_rd,
   output logic [WIDTH-1:0]         wb_data,
   output logic [WIDTH-1:0]         wb_data_nxt
);

   logic [WIDTH-1:0] sel_raw;
   logic [WIDTH-1:0] mem_ext;
   logic             mem_hit;
   wb_state_e        state_q, state_nxt;

   // Out-of-range selects fall through to the zero default.
   always_comb begin
      sel_raw = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (sel == SEL_W'(k)) sel_raw = src_flat[k*WIDTH +: WIDTH];
      end
   end

   generate
      if (MEM_SRC < NUM_SRC && WIDTH == 32) begin : g_ldext
         load_ext u_load_ext (
            .word       (src_flat[MEM_SRC*WIDTH +: WIDTH]),
            .ld_type    (ld_type),
            .ld_addr_lo (ld_addr_lo),
            .data       (mem_ext)
         );
         assign mem_hit = (sel == SEL_W'(MEM_SRC));
      end else begin : g_noext
         assign mem_ext = '0;
         assign mem_hit = 1'b0;
      end
   endgenerate

   assign wb_data_nxt = mem_hit ? mem_ext : sel_raw;

   // Occupancy state: register / next-state / output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      if (flush)       state_nxt = ST_EMPTY;
      else if (!stall) state_nxt = in_valid ? ST_FULL : ST_EMPTY;
   end

   always_comb begin
      wb_valid = (state_q == ST_FULL);
   end

   // Payload register. x0 never writes; data is still captured for trace.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_we   <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else if (flush) begin
         wb_we   <= 1'b0;
         wb_rd   <= '0;
         wb_data <= '0;
      end else if (!stall) begin
         wb_we   <= we_in & in_valid & (rd_in != '0);
         wb_rd   <= rd_in;
         wb_data <= wb_data_nxt;
      end
   end

endmodule

// File: tb/tb_wb_sel_pipe.sv
// tb_wb_sel_pipe: scoreboard bench for wb_sel_pipe.
// Three instances: default (NUM_SRC=4), NUM_SRC=3 (zero on sel=3)
// and NUM_SRC=8/SEL_W=3 for a random select sweep.
module tb_wb_sel_pipe;

   typedef struct {
      logic        valid;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] d;
      logic [31:0] d3;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst, stall, flush, in_valid, we_in;
   logic [7:0][31:0] src, src8;
   logic [1:0]       sel;
   logic [2:0]       sel8;
   logic [2:0]       ld_type;
   logic [1:0]       ld_addr_lo;
   logic [4:0]       rd_in;

   logic        wb_valid, wb_we, v3, we3, v8, we8;
   logic [4:0]  wb_rd, rd3, rd8;
   logic [31:0] wb_data, wb_data_nxt, d3, nxt3, d8, nxt8;

   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   logic [31:0] q8[$];
   exp_t m;

   always #5 clk = ~clk;

   wb_sel_pipe u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .src_flat(src[3:0]), .sel(sel), .ld_type(ld_type), .ld_addr_lo(ld_addr_lo),
      .rd_in(rd_in), .we_in(we_in), .wb_valid(wb_valid), .wb_we(wb_we),
      .wb_rd(wb_rd), .wb_data(wb_data), .wb_data_nxt(wb_data_nxt)
   );

   wb_sel_pipe #(.NUM_SRC(3), .SEL_W(2)) u_n3 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .src_flat(src[2:0]), .sel(sel), .ld_type(ld_type), .ld_addr_lo(ld_addr_lo),
      .rd_in(rd_in), .we_in(we_in), .wb_valid(v3), .wb_we(we3),
      .wb_rd(rd3), .wb_data(d3), .wb_data_nxt(nxt3)
   );

   wb_sel_pipe #(.NUM_SRC(8), .SEL_W(3)) u_n8 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .src_flat(src8), .sel(sel8), .ld_type(ld_type), .ld_addr_lo(ld_addr_lo),
      .rd_in(rd_in), .we_in(we_in), .wb_valid(v8), .wb_we(we8),
      .wb_rd(rd8), .wb_data(d8), .wb_data_nxt(nxt8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   // Reference select/extend, written from the load-type table.
   function automatic logic [31:0] ref_sel(input logic [7:0][31:0] s, input int sl,
                                           input int n, input logic [2:0] lt,
                                           input logic [1:0] lo);
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      if (sl >= n) return 32'h0;
      w = s[sl];
      if (sl != 2) return w;
      b = w[8*int'(lo) +: 8];
      h = lo[1] ? w[31:16] : w[15:0];
      case (lt)
         3'b000:  return {{24{b[7]}}, b};
         3'b100:  return {24'h0, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   // Called at a negedge: drive, check forwarding, push, clock, pop, compare.
   task automatic step(input string tag, input logic iv, input logic we, input logic [4:0] rd,
                       input logic [1:0] s, input logic [2:0] lt, input logic [1:0] lo,
                       input logic st, input logic fl);
      logic [31:0] nx, nx3;
      exp_t e;
      in_valid = iv; we_in = we; rd_in = rd; sel = s;
      ld_type = lt; ld_addr_lo = lo; stall = st; flush = fl;
      nx  = ref_sel(src, int'(s), 4, lt, lo);
      nx3 = ref_sel(src, int'(s), 3, lt, lo);
      #1;
      chk({tag, ".nxt"}, wb_data_nxt, nx);
      if (fl) begin
         m.valid = 1'b0; m.we = 1'b0; m.rd = '0; m.d = '0; m.d3 = '0;
      end else if (!st) begin
         m.valid = iv; m.we = we & iv & (rd != 5'd0); m.rd = rd; m.d = nx; m.d3 = nx3;
      end
      q.push_back(m);
      @(posedge clk); #1;
      if (q.size() == 0) chk({tag, ".qempty"}, 32'h1, 32'h0);
      else begin
         e = q.pop_front();
         chk({tag, ".valid"}, {31'h0, wb_valid}, {31'h0, e.valid});
         chk({tag, ".we"},    {31'h0, wb_we},    {31'h0, e.we});
         chk({tag, ".rd"},    {27'h0, wb_rd},    {27'h0, e.rd});
         chk({tag, ".data"},  wb_data,           e.d);
         chk({tag, ".data3"}, d3,                e.d3);
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; stall = 0; flush = 0; in_valid = 0; we_in = 0;
      src = '0; src8 = '0; sel = 0; sel8 = 0; ld_type = 0; ld_addr_lo = 0; rd_in = 0;
      m = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0};
      #3;
      chk("rst.valid", {31'h0, wb_valid}, 32'h0);
      chk("rst.we",    {31'h0, wb_we},    32'h0);
      chk("rst.rd",    {27'h0, wb_rd},    32'h0);
      chk("rst.data",  wb_data,           32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Load extension on the memory source
      src[0] = 32'h0000_1004; src[1] = 32'h1111_2222; src[2] = 32'h80FF_7F01; src[3] = 32'h0;
      step("lb3",  1, 1, 5'd5, 2'd2, 3'b000, 2'd3, 0, 0);
      step("lhu2", 1, 1, 5'd6, 2'd2, 3'b101, 2'd2, 0, 0);
      step("lh2",  1, 1, 5'd6, 2'd2, 3'b001, 2'd2, 0, 0);
      step("lb1",  1, 1, 5'd7, 2'd2, 3'b000, 2'd1, 0, 0);
      step("lbu3", 1, 1, 5'd7, 2'd2, 3'b100, 2'd3, 0, 0);
      step("lhmis",1, 1, 5'd8, 2'd2, 3'b001, 2'd1, 0, 0);
      step("lw",   1, 1, 5'd8, 2'd2, 3'b010, 2'd3, 0, 0);
      step("ldund",1, 1, 5'd8, 2'd2, 3'b111, 2'd1, 0, 0);
      step("pc4",  1, 1, 5'd1, 2'd0, 3'b000, 2'd3, 0, 0);

      // x0 suppression, zero source, NUM_SRC=3 out-of-range
      src[1] = 32'h1234_5678;
      step("x0",   1, 1, 5'd0, 2'd1, 3'b010, 2'd0, 0, 0);
      step("zero", 1, 1, 5'd4, 2'd3, 3'b010, 2'd0, 0, 0);
      src[3] = 32'h5555_AAAA;
      step("oor3", 1, 1, 5'd4, 2'd3, 3'b010, 2'd0, 0, 0);
      step("bub",  0, 1, 5'd9, 2'd1, 3'b010, 2'd0, 0, 0);

      // Stall holds, flush wins over stall
      src[1] = 32'hA5A5_A5A5;
      step("ldA5", 1, 1, 5'd9, 2'd1, 3'b010, 2'd0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         src[1] = 32'h0BAD_0000 + i;
         step("stall", 1, 1, 5'(10 + i), 2'd1, 3'b010, 2'd0, 1, 0);
      end
      step("stfl", 1, 1, 5'd3, 2'd1, 3'b010, 2'd0, 1, 1);
      step("reld", 1, 1, 5'd3, 2'd1, 3'b010, 2'd0, 0, 0);
      step("fl",   1, 1, 5'd3, 2'd1, 3'b010, 2'd0, 0, 1);

      // Async reset between edges
      src[1] = 32'hDEAD_BEEF;
      step("ldDB", 1, 1, 5'd12, 2'd1, 3'b010, 2'd0, 0, 0);
      #1 rst = 1'b1;
      #1;
      chk("arst.valid", {31'h0, wb_valid}, 32'h0);
      chk("arst.we",    {31'h0, wb_we},    32'h0);
      chk("arst.rd",    {27'h0, wb_rd},    32'h0);
      chk("arst.data",  wb_data,           32'h0);
      #1 rst = 1'b0;
      m = '{1'b0, 1'b0, 5'd0, 32'h0, 32'h0};
      src[1] = 32'h0F0F_1234;
      step("post", 1, 1, 5'd13, 2'd1, 3'b010, 2'd0, 0, 0);

      // Random select sweep on the 8-source instance
      stall = 0; flush = 0; in_valid = 1; we_in = 1; rd_in = 5'd1;
      for (int i = 0; i < 1000; i++) begin
         for (int k = 0; k < 8; k++) src8[k] = $urandom;
         sel8 = 3'($urandom_range(0, 7));
         ld_type = 3'($urandom);
         ld_addr_lo = 2'($urandom);
         q8.push_back(ref_sel(src8, int'(sel8), 8, ld_type, ld_addr_lo));
         @(posedge clk); #1;
         if (q8.size() == 0) chk("sw.qempty", 32'h1, 32'h0);
         else chk("sweep8", d8, q8.pop_front());
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
